// File: rtl/servo_pwm_decoder_pkg.sv
// Shared servo definitions for the PWM generator and the PWM decoder.
// Position codes follow the UART command field encoding. Centre counts are
// high-times in 27 MHz clock cycles, minus one. One servo frame is
// CYCLE_COUNT + 1 cycles long.
package servo_pkg;

    localparam int CYCLE_COUNT     = 539_999;

    localparam int CENTRE_IDLE     = 21_499;
    localparam int CENTRE_PRELOAD  = 12_499;
    localparam int CENTRE_LOAD     = 21_499;
    localparam int CENTRE_DELIVERY = 37_999;
    localparam int CENTRE_TOP      = 42_999;

    // 3-bit arm position / command codes shared with the UART command field.
    // LOAD has the same centre as IDLE, so the decoder reports POS_IDLE for both.
    typedef enum logic [2:0] {
        POS_UNKNOWN   = 3'b000,
        POS_IDLE      = 3'b001,
        POS_PRELOAD   = 3'b010,
        POS_LOAD      = 3'b011,
        POS_DELIVERY  = 3'b100,
        POS_TOP       = 3'b101,
        POS_INCREMENT = 3'b110,
        POS_DECREMENT = 3'b111
    } pos_code_e;

    // Decoder measurement FSM states.
    typedef enum logic [1:0] {
        DEC_SYNC = 2'd0,
        DEC_ARM  = 2'd1,
        DEC_HIGH = 2'd2,
        DEC_LOW  = 2'd3
    } dec_state_e;

endpackage

// File: rtl/servo_pwm_decoder_conditioner.sv
// pwm_in_conditioner: brings the asynchronous PWM pin into the clk domain and
// produces a clean level plus single-cycle rise/fall pulses.
// Build option: PWM_GLITCH_FILTER_EN inserts a FILTER_LEN-sample stability
// filter after the synchronizer. Edge latency is 3 cycles without the filter
// and 3 + FILTER_LEN cycles with it.
// 'ready' rises once the pipeline has flushed its reset contents, so the
// level can be trusted to reflect the pin.
module pwm_in_conditioner
    import servo_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic ready
);

    if (FILTER_LEN < 1) begin : g_filter_len_chk
        $error("FILTER_LEN must be at least 1");
    end

    logic sync_q1;
    logic sync_q2;
    logic level_raw;
    logic level_q;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= pwm_in;
            sync_q2 <= sync_q1;
        end
    end

`ifdef PWM_GLITCH_FILTER_EN
    localparam int FILT_DELAY = FILTER_LEN;
    localparam int RUN_W      = $clog2(FILTER_LEN + 1);

    logic             filt_q;
    logic [RUN_W-1:0] run_cnt;

    // Accept a new level only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q  <= 1'b0;
            run_cnt <= '0;
        end else if (sync_q2 == filt_q) begin
            run_cnt <= '0;
        end else if (run_cnt == RUN_W'(FILTER_LEN - 1)) begin
            filt_q  <= sync_q2;
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    assign level_raw = filt_q;
`else
    localparam int FILT_DELAY = 0;

    assign level_raw = sync_q2;
`endif

    localparam int FILL   = 3 + FILT_DELAY;
    localparam int FILL_W = $clog2(FILL + 1);

    logic [FILL_W-1:0] fill_cnt;

    // Delayed copy of the conditioned level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_raw;
        end
    end

    // Counts the cycles needed to flush reset values out of the pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt <= '0;
        end else if (fill_cnt != FILL_W'(FILL)) begin
            fill_cnt <= fill_cnt + 1'b1;
        end
    end

    assign level = level_raw;
    assign rise  = level_raw & ~level_q;
    assign fall  = ~level_raw & level_q;
    assign ready = (fill_cnt == FILL_W'(FILL));

endmodule

// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder: measures servo PWM high-time and period in clk cycles.
// It classifies the high-time into arm position codes and flags
// out-of-range pulses and loss of signal.
// Build option: PWM_GLITCH_FILTER_EN enables the input glitch filter in
// pwm_in_conditioner.
// Counting: the rise cycle is cycle 1. width is the number of cycles the
// conditioned level was high. period is the number of cycles from rise to rise.
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter int CNT_W            = 20,
    parameter int MIN_WIDTH        = 12_000,
    parameter int MAX_WIDTH        = 44_000,
    parameter int TOL              = 500,
    parameter int TIMEOUT          = 1_080_000,
    parameter int FILTER_LEN       = 8,
    parameter int IDLE_CENTRE      = CENTRE_IDLE,
    parameter int PRELOAD_CENTRE   = CENTRE_PRELOAD,
    parameter int DELIVERY_CENTRE  = CENTRE_DELIVERY,
    parameter int TOP_CENTRE       = CENTRE_TOP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic             sample_valid,
    output logic [CNT_W-1:0] width,
    output logic [CNT_W-1:0] period,
    output logic [2:0]       pos_code,
    output logic             out_of_range,
    output logic             signal_lost
);

    // Adjacent position centres are at least 5000 cycles apart, so the
    // windows stay disjoint while TOL < 2500.
    if (TOL >= 2_500) begin : g_tol_chk
        $error("TOL must be below 2500 so position windows do not overlap");
    end
    if (MIN_WIDTH > MAX_WIDTH) begin : g_range_chk
        $error("MIN_WIDTH must not exceed MAX_WIDTH");
    end
    if (TIMEOUT < 2) begin : g_timeout_chk
        $error("TIMEOUT must be at least 2");
    end

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic signed [CNT_W+1:0] TOL_S = (CNT_W + 2)'(TOL);

    // Absolute distance of w from centre c, compared against the tolerance.
    function automatic logic in_window(input logic [CNT_W-1:0] w,
                                       input logic [CNT_W-1:0] c);
        logic signed [CNT_W+1:0] diff;
        diff = $signed({2'b00, w}) - $signed({2'b00, c});
        if (diff[CNT_W+1]) begin
            diff = -diff;
        end
        return (diff <= TOL_S);
    endfunction

    function automatic logic is_out_of_range(input logic [CNT_W-1:0] w);
        return (w < CNT_W'(MIN_WIDTH)) || (w > CNT_W'(MAX_WIDTH));
    endfunction

    // An out-of-range width is never classified, even if a window matches.
    function automatic logic [2:0] classify(input logic [CNT_W-1:0] w);
        logic [2:0] code;
        code = POS_UNKNOWN;
        if (is_out_of_range(w)) begin
            code = POS_UNKNOWN;
        end else if (in_window(w, CNT_W'(IDLE_CENTRE))) begin
            code = POS_IDLE;
        end else if (in_window(w, CNT_W'(PRELOAD_CENTRE))) begin
            code = POS_PRELOAD;
        end else if (in_window(w, CNT_W'(DELIVERY_CENTRE))) begin
            code = POS_DELIVERY;
        end else if (in_window(w, CNT_W'(TOP_CENTRE))) begin
            code = POS_TOP;
        end
        return code;
    endfunction

    // Counters hold at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic              cond_level;
    logic              cond_rise;
    logic              cond_fall;
    logic              cond_ready;
    logic              any_edge;
    logic              timeout_hit;
    logic [IDLE_W-1:0] idle_cnt;
    dec_state_e        state;
    logic [CNT_W-1:0]  hi_cnt;
    logic [CNT_W-1:0]  per_cnt;
    logic [CNT_W-1:0]  width_hold;
    logic [2:0]        new_code;
    logic              new_oor;

    pwm_in_conditioner #(
        .FILTER_LEN (FILTER_LEN)
    ) u_cond (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .level  (cond_level),
        .rise   (cond_rise),
        .fall   (cond_fall),
        .ready  (cond_ready)
    );

    assign any_edge = cond_rise | cond_fall;

    // An edge in the same cycle as the last idle count wins and clears the counter.
    assign timeout_hit = !any_edge && (idle_cnt == IDLE_W'(TIMEOUT - 1));

    // Classification of the width that the next rise will publish.
    always_comb begin
        new_code = classify(width_hold);
        new_oor  = is_out_of_range(width_hold);
    end

    // Idle counter: cycles since the last conditioned edge, holding at TIMEOUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (any_edge) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_W'(TIMEOUT)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Measurement FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= DEC_SYNC;
            hi_cnt       <= '0;
            per_cnt      <= '0;
            width_hold   <= '0;
            width        <= '0;
            period       <= '0;
            pos_code     <= POS_UNKNOWN;
            out_of_range <= 1'b0;
            signal_lost  <= 1'b1;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (timeout_hit) begin
                // Keep width/period/pos_code. Resynchronise so that a stuck-high
                // input is not measured from mid-pulse.
                signal_lost <= 1'b1;
                state       <= DEC_SYNC;
            end else begin
                case (state)
                    DEC_SYNC: begin
                        if (cond_ready && !cond_level) begin
                            state <= DEC_ARM;
                        end
                    end
                    DEC_ARM: begin
                        if (cond_rise) begin
                            hi_cnt  <= CNT_W'(1);
                            per_cnt <= CNT_W'(1);
                            state   <= DEC_HIGH;
                        end
                    end
                    DEC_HIGH: begin
                        per_cnt <= sat_inc(per_cnt);
                        if (cond_fall) begin
                            width_hold <= hi_cnt;
                            state      <= DEC_LOW;
                        end else begin
                            hi_cnt <= sat_inc(hi_cnt);
                        end
                    end
                    DEC_LOW: begin
                        if (cond_rise) begin
                            width        <= width_hold;
                            period       <= per_cnt;
                            pos_code     <= new_code;
                            out_of_range <= new_oor;
                            signal_lost  <= 1'b0;
                            sample_valid <= 1'b1;
                            hi_cnt       <= CNT_W'(1);
                            per_cnt      <= CNT_W'(1);
                            state        <= DEC_HIGH;
                        end else begin
                            per_cnt <= sat_inc(per_cnt);
                        end
                    end
                    default: state <= DEC_SYNC;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Testbench for servo_pwm_decoder using scaled parameters: centres x1/50,
// TIMEOUT 5000, CNT_W 12 so that counter saturation is reachable.
// Each driven rise that completes a period pushes the expected sample to a
// scoreboard. A monitor pops it on every sample_valid. Build option:
// PWM_GLITCH_FILTER_EN adds a glitch-injection sequence and the longer edge latency.
module tb_servo_pwm_decoder;
    import servo_pkg::*;

    localparam int CNT_W = 12;
    localparam int MIN_W = 100;
    localparam int MAX_W = 900;
    localparam int TOL_C = 50;
    localparam int TMO   = 5000;
    localparam int FLEN  = 8;
    localparam int SAT   = (1 << CNT_W) - 1;
`ifdef PWM_GLITCH_FILTER_EN
    localparam int LAT = 3 + FLEN;
`else
    localparam int LAT = 3;
`endif
    localparam int NVEC = 18;

    typedef struct {
        int         width;
        int         period;
        logic [2:0] code;
        bit         oor;
        int         due;
    } exp_t;

    typedef struct {
        int         hi;
        int         lo;
        logic [2:0] code;
        bit         oor;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             pwm_in = 1'b0;
    logic             sample_valid;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] period;
    logic [2:0]       pos_code;
    logic             out_of_range;
    logic             signal_lost;

    exp_t sb_q[$];
    exp_t pending;
    exp_t mon_e;
    bit   armed;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    vec_t tbl[NVEC];

    servo_pwm_decoder #(
        .CNT_W           (CNT_W),
        .MIN_WIDTH       (MIN_W),
        .MAX_WIDTH       (MAX_W),
        .TOL             (TOL_C),
        .TIMEOUT         (TMO),
        .FILTER_LEN      (FLEN),
        .IDLE_CENTRE     (430),
        .PRELOAD_CENTRE  (250),
        .DELIVERY_CENTRE (760),
        .TOP_CENTRE      (860)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pwm_in       (pwm_in),
        .sample_valid (sample_valid),
        .width        (width),
        .period       (period),
        .pos_code     (pos_code),
        .out_of_range (out_of_range),
        .signal_lost  (signal_lost)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a rise; if a period is being measured, its sample becomes due.
    task automatic drive_rise();
        pwm_in = 1'b1;
        if (armed) begin
            pending.due = cyc + LAT;
            sb_q.push_back(pending);
        end
    endtask

    task automatic send(input int hi, input int lo, input logic [2:0] code, input bit oor);
        drive_rise();
        pending.width  = hi;
        pending.period = (hi + lo > SAT) ? SAT : hi + lo;
        pending.code   = code;
        pending.oor    = oor;
        armed = 1'b1;
        step(hi);
        pwm_in = 1'b0;
        step(lo);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_sample_valid"}, sample_valid, 0);
        chk({tag, "_width"}, width, 0);
        chk({tag, "_period"}, period, 0);
        chk({tag, "_pos_code"}, pos_code, 0);
        chk({tag, "_out_of_range"}, out_of_range, 0);
        chk({tag, "_signal_lost"}, signal_lost, 1);
    endtask

    // Scoreboard monitor: every sample_valid must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && sample_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_sample actual=1 required=0 (cycle %0d, width %0d)", cyc, width);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sample_latency", cyc, mon_e.due);
                chk("width", width, mon_e.width);
                chk("period", period, mon_e.period);
                chk("pos_code", pos_code, mon_e.code);
                chk("out_of_range", out_of_range, mon_e.oor);
                chk("signal_lost_on_sample", signal_lost, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{300, 700, 3'b010, 1'b0};
        tbl[1]  = '{300, 700, 3'b010, 1'b0};
        tbl[2]  = '{300, 700, 3'b010, 1'b0};
        tbl[3]  = '{430, 570, 3'b001, 1'b0};
        tbl[4]  = '{480, 520, 3'b001, 1'b0};
        tbl[5]  = '{481, 519, 3'b000, 1'b0};
        tbl[6]  = '{760, 240, 3'b100, 1'b0};
        tbl[7]  = '{860, 140, 3'b101, 1'b0};
        tbl[8]  = '{900, 100, 3'b101, 1'b0};
        tbl[9]  = '{950, 100, 3'b000, 1'b1};
        tbl[10] = '{50, 950, 3'b000, 1'b1};
        tbl[11] = '{100, 900, 3'b000, 1'b0};
        tbl[12] = '{99, 901, 3'b000, 1'b1};
        tbl[13] = '{200, 800, 3'b010, 1'b0};
        tbl[14] = '{199, 801, 3'b000, 1'b0};
        tbl[15] = '{300, 4000, 3'b010, 1'b0};
        tbl[16] = '{600, 400, 3'b000, 1'b0};
        tbl[17] = '{910, 90, 3'b000, 1'b1};
        pending = '{0, 0, 3'b000, 1'b0, 0};
        armed   = 1'b0;

        // Reset state
        #1 rst = 1'b1;
        step(3);
        chk_reset_values("reset");
        rst = 1'b0;
        step(20);

        // Table-driven stream; the first rise only starts counting
        for (int i = 0; i < NVEC; i++) begin
            send(tbl[i].hi, tbl[i].lo, tbl[i].code, tbl[i].oor);
            if (i == 0) chk("lost_before_first_sample", signal_lost, 1);
        end
        send(300, 700, 3'b010, 1'b0);

        // Stuck-high input: signal_lost exactly TIMEOUT cycles after the last edge
        drive_rise();
        armed = 1'b0;
        repeat (LAT + TMO - 1) @(posedge clk);
        @(negedge clk);
        chk("lost_before_timeout", signal_lost, 0);
        @(negedge clk);
        chk("lost_at_timeout", signal_lost, 1);
        chk("held_width", width, 300);
        chk("held_period", period, 1000);
        chk("held_pos_code", pos_code, 3'b010);
        step(200);
        pwm_in = 1'b0;
        step(700);
        send(300, 700, 3'b010, 1'b0);
        chk("lost_until_recovery", signal_lost, 1);
        send(430, 570, 3'b001, 1'b0);

        // Async reset in the middle of a high phase, released while high
        drive_rise();
        step(100);
        rst = 1'b1;
        #1;
        chk_reset_values("midpulse_reset");
        armed = 1'b0;
        step(3);
        rst = 1'b0;
        step(200);
        pwm_in = 1'b0;
        step(700);
        send(300, 700, 3'b010, 1'b0);
        send(760, 240, 3'b100, 1'b0);
        send(860, 140, 3'b101, 1'b0);

`ifdef PWM_GLITCH_FILTER_EN
        // Short low glitches inside the high phase must not change the width
        drive_rise();
        pending = '{300, 1000, 3'b010, 1'b0, 0};
        armed = 1'b1;
        step(100);
        pwm_in = 1'b0;
        step(3);
        pwm_in = 1'b1;
        step(100);
        pwm_in = 1'b0;
        step(3);
        pwm_in = 1'b1;
        step(94);
        pwm_in = 1'b0;
        step(700);
        send(300, 700, 3'b010, 1'b0);
`endif

        // Close the last period and let the scoreboard drain
        drive_rise();
        step(50);
        pwm_in = 1'b0;
        step(50);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/servo_pwm_decoder.md
Name: servo_pwm_decoder

Overview:
- Measures an incoming servo PWM signal (arm servo line or loop-back of the generator output).
- Reports high-time and period in clk cycles and classifies high-time into arm position codes, using the same encoding as the UART command field.
- Flags loss of signal and out-of-range pulses.
- Feeds the status/telemetry path and closed-loop checks of the arm controller.

Parameters:
- CNT_W, 20, width of width/period counters; counters saturate at 2**CNT_W-1.
- MIN_WIDTH, 12_000, smallest legal high-time in cycles.
- MAX_WIDTH, 44_000, largest legal high-time in cycles.
- TOL, 500, ± window in cycles for position classification.
- TIMEOUT, 1_080_000, cycles without any edge before signal_lost is set (2 periods at 27 MHz).
- FILTER_LEN, 8, stable-sample count used only when PWM_GLITCH_FILTER_EN is defined.

Ports:
- clk  in  1  system clock, 27 MHz.
- rst  in  1  asynchronous, active-high reset.
- pwm_in  in  1  asynchronous PWM input.
- sample_valid  out  1  one-cycle pulse when a full period has been measured.
- width  out  CNT_W  last measured high-time in cycles; held between pulses.
- period  out  CNT_W  last measured rise-to-rise period in cycles; held between pulses.
- pos_code  out  3  classified position: 3'b001 idle/load, 3'b010 preload, 3'b100 delivery, 3'b101 top, 3'b000 unknown.
- out_of_range  out  1  last width was < MIN_WIDTH or > MAX_WIDTH.
- signal_lost  out  1  no edge seen for TIMEOUT cycles.

Behaviour:
- Reset values: sample_valid=0, width=0, period=0, pos_code=0, out_of_range=0, signal_lost=1. FSM goes to SYNC; counters clear.
- Input path: 2-flop synchronizer, then a registered copy for edge detection. rise/fall are detected 3 cycles after the pin edge.
- FSM states:
  - SYNC: wait for the synchronized input to be low. Measurement must never start mid-pulse.
  - ARM: wait for rise. On rise, clear hi_cnt and per_cnt, go to HIGH.
  - HIGH: hi_cnt and per_cnt increment each cycle. On fall, latch hi_cnt into an internal width_hold, go to LOW.
  - LOW: per_cnt increments. On rise:
    - width <= width_hold, period <= per_cnt, pulse sample_valid.
    - Update pos_code and out_of_range in the same cycle.
    - Restart hi_cnt and per_cnt, go to HIGH.
- Counting rule: the rise cycle counts as cycle 1. width = number of cycles the synchronized input was high. period = cycles from one rise to the next.
- Classification (combinational on the new width, registered with sample_valid). Centres are 21_499 idle, 12_499 preload, 37_999 delivery, 42_999 top.
  - |width-centre| <= TOL selects that code.
  - No window matches: pos_code = 0.
  - out_of_range=1 forces pos_code=0.
  - Windows must not overlap: require TOL < 2_500, checked by an elaboration assertion.
- Saturation: hi_cnt and per_cnt stop at all-ones and do not wrap.
- Timeout:
  - An idle counter clears on any edge and increments otherwise.
  - On reaching TIMEOUT: signal_lost<=1, FSM to SYNC (a stuck-high input waits for low), no sample_valid.
  - width, period and pos_code keep their last values.
  - signal_lost clears only together with the next sample_valid.
- First period after reset or loss produces no sample_valid, because the SYNC/ARM rise only starts counting.
- Simultaneous timeout and edge in the same cycle: the edge wins and the idle counter clears.
- Async reset mid-pulse returns to reset values immediately. The FSM resynchronises through SYNC.

Optional Feature:
- PWM_GLITCH_FILTER_EN defined: a filtered level replaces the synchronizer output.
  - The filtered level changes only after FILTER_LEN consecutive equal samples.
  - Edge latency becomes 3+FILTER_LEN cycles.
  - Pulses shorter than FILTER_LEN cycles are ignored. Measured width is unchanged for clean signals, since both edges are delayed equally.
- Undefined: raw 2-flop synchronizer, 3-cycle edge latency, no filtering.

Decomposition:
- Shared package `servo_pkg`: position centre counts (idle 21_499, preload 12_499, load 21_499, delivery 37_999, top 42_999), 3-bit position/state codes (IDLE..DECREMENT), cycle_count 539_999.
- The generator shares this package.
- One sub-module, `pwm_in_conditioner`: synchronizer, optional glitch filter, and rise/fall pulse outputs.

Test Plan:
- Sim params (TIMEOUT=5000, MIN_WIDTH=100, MAX_WIDTH=900, TOL=50, centres scaled ×1/50): drive period 1000, high 300 for 3 periods.
  - First sample_valid occurs at the second rise.
  - width=300, period=1000, signal_lost 1→0 with that pulse.
- Default params: drive high 21_499, period 540_000 → pos_code=001. Drive high 42_999 → pos_code=101. Drive high 30_000 → pos_code=000, out_of_range=0.
- Width 50 (sim params) → out_of_range=1, pos_code=000. Width 950 → same result.
- Hold pwm_in high after a valid stream:
  - signal_lost=1 exactly TIMEOUT cycles after the last edge.
  - No sample_valid, outputs held.
  - Resume the stream → recovery sample at the second rise.
- Assert rst in the middle of a HIGH phase → all outputs at reset values. Release while the input is high → no sample until a low, rise, rise sequence.
- With PWM_GLITCH_FILTER_EN and FILTER_LEN=8: inject 3-cycle low glitches inside the high phase → width stays 300 and there are no extra sample_valid pulses.
